// File: rtl/pc_redirect_ctrl_if.sv
// Fetch-PC / redirect bundle between the EX-stage branch logic (master)
// and the PC redirect controller (slave).
interface pc_redirect_ctrl_if #(
    parameter int PC_W  = 9,
    parameter int CNT_W = 16
);
    logic             imem_ready;
    logic             stall;
    logic             ex_valid;
    logic             ex_branch;
    logic             pc_sel;
    logic [31:0]      br_pc;
    logic [PC_W-1:0]  pc;
    logic             flush_ifid;
    logic             flush_idex;
    logic             misalign_err;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] redirect_cnt;

    modport master (
        output imem_ready, stall, ex_valid, ex_branch, pc_sel, br_pc,
        input  pc, flush_ifid, flush_idex, misalign_err, branch_cnt, redirect_cnt
    );

    modport slave (
        input  imem_ready, stall, ex_valid, ex_branch, pc_sel, br_pc,
        output pc, flush_ifid, flush_idex, misalign_err, branch_cnt, redirect_cnt
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC register with EX-resolved redirect sequencing, pipeline flushes,
// misaligned-target halt and saturating branch/redirect statistics.
//
// state | meaning
// RUN   | normal fetch; sequential advance or immediate redirect
// HOLD  | redirect accepted, waiting for imem_ready to load pend_pc
// HALT  | misaligned redirect target seen; frozen until reset
module pc_redirect_ctrl #(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    pc_redirect_ctrl_if.slave bus
);

    typedef enum logic [1:0] {RUN, HOLD, HALT} state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  pend_pc_q, pend_pc_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
    logic             flush_ifid, flush_idex;

    logic             redir_req;
    logic             misaligned;
    logic [PC_W-1:0]  target;
    logic             unused_br_pc_hi;

    assign redir_req       = bus.ex_valid && bus.pc_sel;
    assign misaligned      = (bus.br_pc[1:0] != 2'b00);
    assign target          = bus.br_pc[PC_W-1:0];
    // Targets beyond the fetch address space are simply truncated.
    assign unused_br_pc_hi = ^bus.br_pc[31:PC_W];

    // Next-state, next-PC, counters and combinational flushes.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        pend_pc_d      = pend_pc_q;
        misalign_d     = misalign_q;
        branch_cnt_d   = branch_cnt_q;
        redirect_cnt_d = redirect_cnt_q;
        flush_ifid     = 1'b0;
        flush_idex     = 1'b0;

        case (state_q)
            RUN: begin
                if (bus.ex_valid && bus.ex_branch && (branch_cnt_q != '1))
                    branch_cnt_d = branch_cnt_q + CNT_W'(1);
                if (redir_req) begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    if (misaligned) begin
                        misalign_d = 1'b1;
                        state_d    = HALT;
                    end else if (bus.imem_ready) begin
                        // Redirect wins over a load-use stall.
                        pc_d = target;
                        if (redirect_cnt_q != '1)
                            redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
                    end else begin
                        pend_pc_d = target;
                        state_d   = HOLD;
                    end
                end else if (bus.imem_ready && !bus.stall) begin
                    pc_d = pc_q + PC_W'(4);
                end
            end
            HOLD: begin
                // ID/EX was already cleared in the accepting cycle; keep
                // squashing whatever IF presents until the target loads.
                flush_ifid = 1'b1;
                if (bus.imem_ready) begin
                    pc_d    = pend_pc_q;
                    state_d = RUN;
                    if (redirect_cnt_q != '1)
                        redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
                end
            end
            HALT: begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    // State and datapath registers, asynchronously reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= RUN;
            pc_q           <= RESET_PC;
            pend_pc_q      <= '0;
            misalign_q     <= 1'b0;
            branch_cnt_q   <= '0;
            redirect_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            pend_pc_q      <= pend_pc_d;
            misalign_q     <= misalign_d;
            branch_cnt_q   <= branch_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.misalign_err = misalign_q;
    assign bus.branch_cnt   = branch_cnt_q;
    assign bus.redirect_cnt = redirect_cnt_q;
    // Flushes are suppressed while reset is held.
    assign bus.flush_ifid   = flush_ifid && !reset;
    assign bus.flush_idex   = flush_idex && !reset;

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Owns the fetch PC register and sequences control-flow redirects resolved in EX by the branch unit (pc_sel/br_pc). It generates the IF/ID and ID/EX flushes and holds a redirect pending while instruction memory is not ready. It halts on misaligned targets and keeps saturating branch statistics counters. It sits between the EX-stage branch logic and the IF stage, replacing the plain PC mux/register.

Parameters:
PC_W, 9, width of the fetch PC (byte address)
RESET_PC, 0, PC value loaded on reset (PC_W bits)
CNT_W, 16, width of the performance counters

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_ready  input  1  instruction memory accepts a fetch this cycle
stall  input  1  ID hazard stall (load-use); freezes sequential PC advance
ex_valid  input  1  EX stage holds a real (non-bubble) instruction
ex_branch  input  1  EX instruction is a conditional branch
pc_sel  input  1  redirect requested by EX (taken branch, jal, jalr)
br_pc  input  32  redirect target from EX
pc  output  PC_W  current fetch address
flush_ifid  output  1  clear IF/ID register this cycle
flush_idex  output  1  clear ID/EX register this cycle
misalign_err  output  1  sticky: misaligned redirect target seen
branch_cnt  output  CNT_W  EX-valid conditional branches seen
redirect_cnt  output  CNT_W  redirects applied to pc

Behaviour:
- Reset (async, any state): pc=RESET_PC, state=RUN, pend_pc=0, misalign_err=0, counters=0. flush_ifid and flush_idex are 0 while reset is high.
- States: RUN, HOLD (redirect pending), HALT.
- redir_req = ex_valid && pc_sel, evaluated in RUN only. Misaligned when br_pc[1:0]!=0. Target = br_pc[PC_W-1:0]; upper bits are ignored.
- RUN, no redir_req:
  - imem_ready && !stall: pc <= pc+4, modulo 2^PC_W (wraps to 0).
  - Otherwise pc holds.
  - Flushes are 0.
- RUN, redir_req, aligned:
  - flush_ifid=flush_idex=1 combinationally in the same cycle.
  - If imem_ready: pc <= target at the next edge, stall ignored (redirect overrides stall), redirect_cnt++. Stay in RUN.
  - If !imem_ready: pend_pc <= target, next state HOLD, pc holds.
- HOLD:
  - flush_ifid=1 and flush_idex=0 every cycle. ex_valid, pc_sel and stall are ignored.
  - On imem_ready: pc <= pend_pc, redirect_cnt++, next state RUN.
- RUN, redir_req, misaligned:
  - flush_ifid=flush_idex=1 that cycle. pc unchanged. misalign_err <= 1. Next state HALT. redirect_cnt unchanged.
- HALT:
  - pc frozen. flush_ifid=flush_idex=1 continuously. misalign_err stays 1.
  - Counters frozen. Exit only via reset.
- branch_cnt increments when ex_valid && ex_branch in RUN, independent of pc_sel/imem_ready. A misaligned branch in RUN is still counted.
- Counters saturate at 2^CNT_W-1; no wrap.
- Redirect target equal to the current pc is a legal redirect: flush and count normally.
- Reset asserted in HOLD discards pend_pc; pc returns to RESET_PC.
- All outputs except the flushes are registered. The flushes are combinational from state and inputs, zero-latency.

Test Plan:
1. Sequential fetch: reset, imem_ready=1, stall=0 for 5 cycles -> pc=0,4,8,12,16,20; flushes 0. With PC_W=9 from pc=508 -> next pc=0.
2. Stall: pc=8, stall=1 for 3 cycles -> pc stays 8. Then a redirect with stall=1, imem_ready=1, br_pc=0x40 -> flush_ifid=flush_idex=1 that cycle, pc=0x40 next cycle, redirect_cnt=1.
3. Pending redirect: br_pc=0x80 with imem_ready=0 for 3 cycles -> state HOLD, pc unchanged, flush_ifid=1/flush_idex=0 in the HOLD cycles. imem_ready rises -> pc=0x80 next cycle, RUN, redirect_cnt incremented once.
4. Misaligned: br_pc=0x42 with pc_sel=1 -> flushes 1, misalign_err=1 next cycle, pc frozen for 10 cycles. Async reset mid-cycle -> pc=RESET_PC and misalign_err=0 immediately.
5. Counters: 4 cycles of ex_valid=ex_branch=1 with pc_sel=1,0,1,0 and imem_ready=1 -> branch_cnt=4, redirect_cnt=2. ex_valid=0 with ex_branch=pc_sel=1 -> no count, no redirect.
6. Saturation: CNT_W=2, 5 counted branches -> branch_cnt=3. Reset asserted during HOLD -> pc=RESET_PC, RUN, pending target discarded.
